hs_fifo_responder: RTL
======================

// Module: hs_fifo_responder
// PURPOSE
//   Destination end of the 4-phase bundled-data stb/ack crossing: sits in the receive clock domain.
//   Synchronises the incoming strobe, captures the bundled data word into a small FIFO, then
//   returns ack. Presents the buffered words downstream on a valid/ready interface.
//   Withholds ack while the FIFO is full, which applies backpressure to the sender.
// PARAMETERS
//   DATA_BITS    8  width of the bundled data word
//   DEPTH        4  FIFO entries; power of 2, >= 2
//   SYNC_STAGES  2  flops in the stb_in synchroniser; >= 2
// PORTS
//   clk        in   1                  receive-domain clock
//   rst        in   1                  asynchronous, active-high reset
//   stb_in     in   1                  request strobe from the sender domain (asynchronous)
//   data_in    in   DATA_BITS          bundled data; stable while stb_in=1 and until ack is seen
//   ack_out    out  1                  acknowledge to the sender; registered, glitch-free
//   out_data   out  DATA_BITS          FIFO head word; 0 when out_valid=0
//   out_valid  out  1                  FIFO not empty
//   out_ready  in   1                  downstream accepts the head word
//   level      out  $clog2(DEPTH)+1    current FIFO occupancy, 0..DEPTH
//   stall      out  1                  request is pending but blocked by a full FIFO
// BEHAVIOUR
//   Reset is rst, asynchronous, active-high; clock is clk.
//   Reset clears: sync flops, FSM (IDLE), pointers, ack_out, out_valid, level, stall -> 0.
//   Reset also discards FIFO contents. Storage array is not reset.
//   Synchroniser: SYNC_STAGES-flop chain on stb_in; its last flop is stb_s. No other logic
//   reads stb_in.
//   FSM, two states:
//     IDLE: ack_out=0.
//       stb_s=1 and !full -> write data_in at wr_ptr; next state ACK.
//       stb_s=1 and full  -> stay IDLE; stall=1 (combinational).
//     ACK: ack_out=1 (ack_out is a registered decode of state==ACK).
//       Stay in ACK while stb_s=1; go to IDLE on stb_s=0.
//   Exactly one FIFO write per stb rising phase. A held stb never writes twice.
//   Latency: stb_in rises before edge 1 -> stb_s=1 after edge SYNC_STAGES.
//     At edge SYNC_STAGES+1: write, ack_out=1, and out_valid=1 if the FIFO was empty.
//   ack_out falls one edge after stb_s is seen low (edge SYNC_STAGES+1 after stb_in falls).
//   FIFO: rd/wr pointers carry an extra wrap bit.
//     empty = (rd == wr).
//     full  = (addr equal, wrap bit differs).
//     level = wr - rd, computed modulo 2*DEPTH.
//   Pop: out_valid && out_ready advances rd at the edge. out_data is fall-through from mem[rd].
//   Simultaneous events:
//     Push and pop in one cycle, not full: both occur; level unchanged.
//     When full: push is judged on pre-edge full, so it is blocked that cycle even if a pop
//       occurs. Push proceeds on the next cycle.
//     Pop when empty: ignored.
//   Wrap-around: pointers wrap modulo 2*DEPTH; data order is preserved across wrap.
//   Reset mid-handshake: ack_out drops immediately. If stb_in is still 1 after reset release,
//     it is a new request: it is captured again after the sync latency (sender must tolerate).
//   ack_out never rises while the FIFO is full.
//   ack_out never changes in the same cycle it is sampled high twice by the FSM.
// TESTING
//   T1 single: stb_in=1, data_in=8'hA5, SYNC_STAGES=2 ->
//      ack_out=1 and out_valid=1 at edge 3, out_data=8'hA5, level=1.
//      Then drop stb -> ack_out=0 two edges + 1 later.
//   T2 hold: stb_in held high 20 cycles, out_ready=0 -> exactly one write; level stays 1.
//   T3 full: out_ready=0, four transfers 01..04, fifth stb with 8'h05 ->
//      level=4, stall=1, ack_out stays 0.
//      Then out_ready=1 for 1 cycle -> 8'h01 popped; 05 written next edge; ack_out=1.
//   T4 push+pop at level=2 -> level stays 2, output order intact.
//   T5 wrap: 10 transfers 10..19 with out_ready=1 -> outputs 10..19 in order, none lost or
//      duplicated.
//   T6 reset while ack_out=1 and level=3 -> ack_out, out_valid, level = 0 asynchronously.
//      stb_in still high -> re-captured 3 edges after release.

Source files
------------

// File: rtl/hs_fifo_responder.sv
// rtl/hs_fifo_responder.sv - receive end of a 4-phase stb/ack crossing feeding a valid/ready FIFO
//
// Synchronises stb_in, captures data_in into a small FIFO once per strobe, returns a
// registered ack_out, and presents buffered words downstream. Ack is withheld while the
// FIFO is full, which backpressures the sender.
//
// Ports:
//   clk        receive-domain clock
//   rst        asynchronous, active-high reset
//   stb_in     request strobe from the sender domain (asynchronous)
//   data_in    bundled data word, stable while stb_in=1 and until ack is seen
//   ack_out    acknowledge back to the sender (registered)
//   out_data   FIFO head word, 0 when out_valid=0
//   out_valid  FIFO not empty
//   out_ready  downstream accepts the head word
//   level      FIFO occupancy, 0..DEPTH
//   stall      request pending but blocked by a full FIFO
module hs_fifo_responder #(
    parameter int DATA_BITS   = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stb_in,
    input  logic [DATA_BITS-1:0]       data_in,
    output logic                       ack_out,
    output logic [DATA_BITS-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       stall
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Strobe synchroniser. Nothing else looks at stb_in.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stb_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], stb_in};
        end
    end

    assign stb_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FIFO pointers carry one extra wrap bit so full and empty differ.
    // ------------------------------------------------------------------
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Handshake FSM. Writing only on the IDLE->ACK transition guarantees a
    // single capture per strobe phase however long stb is held.
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stb_s) begin
                    // Full is judged on the pre-edge pointers, so a pop in the
                    // same cycle does not unblock the push until the next one.
                    if (!full) begin
                        push    = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (!stb_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ack comes straight from a flop so the sender never sees a glitch.
    logic ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= (state_d == ST_ACK);
        end
    end

    assign ack_out = ack_q;

    // ------------------------------------------------------------------
    // Pointer update and storage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is deliberately not reset; reset empties the FIFO via the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    assign out_valid = !empty;
    assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
    // Natural wrap of the AW+1 bit subtraction gives occupancy modulo 2*DEPTH.
    assign level     = wr_ptr - rd_ptr;

endmodule
